// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: register-index width and
// the hazard controller's sequencing states.
package cpu_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use bubble, branch flush, data-memory freeze
// with a sticky timeout, and a stall-cycle statistic.
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic              ID_uses_rt,
    input  logic              EX_mem_read,
    input  logic [REG_W-1:0]  EX_Rd,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    input  logic              stat_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_en,
    output logic              mem_timeout,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e          state_q;
    state_e          state_d;
    logic [WC_W-1:0] wait_cnt_q;
    logic [WC_W-1:0] wait_cnt_d;
    logic            load_use;
    logic            mem_wait;
    logic            decode;

    assign load_use = EX_mem_read && (EX_Rd != '0) &&
                      ((EX_Rd == ID_Rs) ||
                       (ID_uses_rt && (EX_Rd == ID_Rt)));
    assign mem_wait = dmem_req && !dmem_ready;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        pipe_en     = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        decode      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = WC_W'(1);
                end else begin
                    decode = 1'b1;
                end
            end
            MEM_WAIT: begin
                // A dropped request releases the freeze just like ready.
                if (!mem_wait) begin
                    decode     = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                    if (wait_cnt_q == WC_LAST) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ERROR: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_en     = 1'b0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (decode) begin
            if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem_timeout = (state_q == ERROR);

    sat_counter #(
        .W(STAT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .arst (arst),
        .en   (!pc_write),
        .clr  (stat_clr),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a
// cycle-level reference model built from the sequencing rules.
module tb_hazard_controller;

    localparam int TMO  = 16;
    localparam int SW   = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [4:0]    ID_Rs = '0;
    logic [4:0]    ID_Rt = '0;
    logic          ID_uses_rt = 1'b0;
    logic          EX_mem_read = 1'b0;
    logic [4:0]    EX_Rd = '0;
    logic          branch_taken = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          stat_clr = 1'b0;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          pipe_en;
    logic          mem_timeout;
    logic [SW-1:0] stall_cycles;

    hazard_controller #(
        .MEM_TIMEOUT(TMO),
        .STAT_W     (SW)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_uses_rt  (ID_uses_rt),
        .EX_mem_read (EX_mem_read),
        .EX_Rd       (EX_Rd),
        .branch_taken(branch_taken),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .stat_clr    (stat_clr),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .pipe_en     (pipe_en),
        .mem_timeout (mem_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    // Reference model: error flag, consecutive wait cycles, stall total.
    bit m_err;
    int m_waited;
    int m_stall;
    bit m_mw;
    logic e_pc, e_ifw, e_iff, e_idf, e_pe;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urt,
                          input bit mr, input int rd, input bit br,
                          input bit req, input bit rdy, input bit clr);
        ID_Rs        = 5'(rs);
        ID_Rt        = 5'(rt);
        ID_uses_rt   = urt;
        EX_mem_read  = mr;
        EX_Rd        = 5'(rd);
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        stat_clr     = clr;
    endtask

    task automatic model_comb();
        bit lu;
        lu = EX_mem_read && (EX_Rd != 0) &&
             ((EX_Rd == ID_Rs) || (ID_uses_rt && (EX_Rd == ID_Rt)));
        m_mw = dmem_req && !dmem_ready;
        e_pc = 1; e_ifw = 1; e_pe = 1; e_iff = 0; e_idf = 0;
        if (m_err || m_mw) begin
            e_pc = 0; e_ifw = 0; e_pe = 0;
        end else if (branch_taken) begin
            e_iff = 1; e_idf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, ".pc_write"}, pc_write, e_pc);
        chk({tag, ".if_id_write"}, if_id_write, e_ifw);
        chk({tag, ".if_id_flush"}, if_id_flush, e_iff);
        chk({tag, ".id_ex_flush"}, id_ex_flush, e_idf);
        chk({tag, ".pipe_en"}, pipe_en, e_pe);
    endtask

    task automatic tick(input string tag);
        #1;
        model_comb();
        chk_comb(tag);
        @(posedge clk);
        if (stat_clr) m_stall = 0;
        else if (!e_pc && m_stall < SMAX) m_stall++;
        if (!m_err) begin
            if (m_mw) begin
                m_waited++;
                if (m_waited >= TMO) m_err = 1;
            end else begin
                m_waited = 0;
            end
        end
        #1;
        chk({tag, ".mem_timeout"}, mem_timeout, m_err);
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        arst = 1'b1;
        #1;
        m_err = 0; m_waited = 0; m_stall = 0;
        chk("rst.stall_cycles", stall_cycles, 0);
        chk("rst.mem_timeout", mem_timeout, 0);
        chk("rst.pc_write", pc_write, 1);
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    initial begin
        int base;
        do_reset();

        // Load-use on rs: one bubble, then free flow.
        set_in(5, 0, 0, 1, 5, 0, 0, 0, 0);
        tick("t1.bubble");
        chk("t1.stall_one", stall_cycles, 1);
        set_in(5, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("t1.after");

        // rt not used, and Rd==0: no stall.
        set_in(0, 5, 0, 1, 5, 0, 0, 0, 0);
        tick("t2.rt_unused");
        set_in(0, 0, 1, 1, 0, 0, 0, 0, 0);
        tick("t2.rd_zero");
        set_in(1, 7, 1, 1, 7, 0, 0, 0, 0);
        tick("t2.rt_used");

        // Branch beats load-use.
        base = m_stall;
        set_in(5, 0, 0, 1, 5, 1, 0, 0, 0);
        tick("t3.branch");
        chk("t3.stall_same", stall_cycles, base);

        // Memory ready after three wait cycles.
        base = m_stall;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick("t4.wait");
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick("t4.ready");
        chk("t4.stall_three", stall_cycles, base + 3);

        // Wait released by dropped request, with load-use held.
        set_in(2, 0, 0, 1, 2, 0, 1, 0, 0);
        tick("t4b.wait");
        set_in(2, 0, 0, 1, 2, 0, 0, 0, 0);
        tick("t4b.drop");

        // stat_clr beats a stall cycle.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick("t6.clr_stall");
        chk("t6.clr_zero", stall_cycles, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("t6.clr_done");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom),
                   ($urandom_range(0, 15) == 0));
            tick("rnd");
        end

        // Timeout: never ready.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (TMO - 1) tick("t5.wait");
        chk("t5.not_yet", mem_timeout, 0);
        tick("t5.last");
        chk("t5.timeout", mem_timeout, 1);
        set_in(3, 0, 0, 1, 3, 1, 1, 1, 0);
        repeat (5) tick("t5.late_ready");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (50) tick("t5.error");
        chk("t5.saturated", stall_cycles, SMAX);

        // Asynchronous reset on saturated counter in ERROR.
        #2 arst = 1'b1;
        #1;
        m_err = 0; m_waited = 0; m_stall = 0;
        chk("t6.async_stall", stall_cycles, 0);
        chk("t6.async_tmo", mem_timeout, 0);
        chk("t6.async_pc", pc_write, 1);
        @(posedge clk);
        #1 arst = 1'b0;

        // Reset mid-wait: back to RUN, no flush.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick("t6.wait");
        #2 arst = 1'b1;
        #1;
        m_err = 0; m_waited = 0; m_stall = 0;
        chk("t6.mid_stall", stall_cycles, 0);
        chk("t6.mid_iff", if_id_flush, 0);
        chk("t6.mid_idf", id_ex_flush, 0);
        @(posedge clk);
        #1 arst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("t6.run");
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (TMO - 1) tick("t6.fresh_wait");
        chk("t6.fresh_count", mem_timeout, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
